// File: rtl/mips_isa_pkg.sv
// -----------------------------------------------------------------------------
// mips_isa_pkg
// Shared MIPS ISA definitions for the instruction fetch/decode path and the
// program loader:
//   - 5-bit internal op codes (same numbering as the decoder output)
//   - 6-bit primary opcodes and R-type funct codes
//   - instruction field bit positions
//   - loader FSM state enum
//   - helpers that pack R/I/J-format words with unused fields forced to 0
// -----------------------------------------------------------------------------
package mips_isa_pkg;

  // Internal op codes; 0 and 21..31 are illegal.
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_ADDU  = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_DIV   = 5'd4;
  localparam logic [4:0] OP_MULT  = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SUB   = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_J     = 5'd11;
  localparam logic [4:0] OP_JAL   = 5'd12;
  localparam logic [4:0] OP_ADDI  = 5'd13;
  localparam logic [4:0] OP_ADDIU = 5'd14;
  localparam logic [4:0] OP_ANDI  = 5'd15;
  localparam logic [4:0] OP_ORI   = 5'd16;
  localparam logic [4:0] OP_BEQ   = 5'd17;
  localparam logic [4:0] OP_BNE   = 5'd18;
  localparam logic [4:0] OP_LW    = 5'd19;
  localparam logic [4:0] OP_SW    = 5'd20;

  // Primary opcodes (bits 31:26).
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type funct codes (bits 5:0).
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_XOR  = 6'b100110;

  // Field LSB positions.
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD0,
    ST_RD1,
    ST_CMP,
    ST_RESP
  } state_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    logic [31:0] w;
    w                  = '0;
    w[OPC_LSB +: 6]    = OPC_RTYPE;
    w[RS_LSB +: 5]     = rs;
    w[RT_LSB +: 5]     = rt;
    w[RD_LSB +: 5]     = rd;
    w[SHAMT_LSB +: 5]  = shamt;
    w[5:0]             = funct;
    return w;
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w               = '0;
    w[OPC_LSB +: 6] = opc;
    w[RS_LSB +: 5]  = rs;
    w[RT_LSB +: 5]  = rt;
    w[15:0]         = imm;
    return w;
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// -----------------------------------------------------------------------------
// instr_field_packer
// Combinational encoder: internal op code plus operand fields -> 32-bit MIPS
// word. Fields not used by the selected format are encoded as 0.
// Ports:
//   op_code                in  5   internal op code
//   rs, rt, rd, shamt      in  5   register / shift fields
//   imm                    in  16  I-type immediate
//   target                 in  26  J-type target
//   word                   out 32  encoded instruction (0 when illegal)
//   illegal                out 1   op code outside 1..20
// -----------------------------------------------------------------------------
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_code,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    word    = '0;
    illegal = 1'b0;
    unique case (op_code)
      OP_ADD:   word = pack_r(rs, rt, rd, shamt, FN_ADD);
      OP_ADDU:  word = pack_r(rs, rt, rd, shamt, FN_ADDU);
      OP_AND:   word = pack_r(rs, rt, rd, shamt, FN_AND);
      OP_DIV:   word = pack_r(rs, rt, rd, shamt, FN_DIV);
      OP_MULT:  word = pack_r(rs, rt, rd, shamt, FN_MULT);
      OP_OR:    word = pack_r(rs, rt, rd, shamt, FN_OR);
      OP_NOR:   word = pack_r(rs, rt, rd, shamt, FN_NOR);
      OP_SLL:   word = pack_r(rs, rt, rd, shamt, FN_SLL);
      OP_SUB:   word = pack_r(rs, rt, rd, shamt, FN_SUB);
      OP_XOR:   word = pack_r(rs, rt, rd, shamt, FN_XOR);
      OP_J:     word = pack_j(OPC_J, target);
      OP_JAL:   word = pack_j(OPC_JAL, target);
      OP_ADDI:  word = pack_i(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: word = pack_i(OPC_ADDIU, rs, rt, imm);
      OP_ANDI:  word = pack_i(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = pack_i(OPC_ORI, rs, rt, imm);
      OP_BEQ:   word = pack_i(OPC_BEQ, rs, rt, imm);
      OP_BNE:   word = pack_i(OPC_BNE, rs, rt, imm);
      OP_LW:    word = pack_i(OPC_LW, rs, rt, imm);
      OP_SW:    word = pack_i(OPC_SW, rs, rt, imm);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Encodes one instruction per transaction and writes it into the shared 32x32
// instruction/data memory at an auto-incrementing pointer, optionally reading
// it back to verify. Used to load programs before fetch starts at BASE_ADDR.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid / in_ready       request handshake (ready only in IDLE)
//   op_code, rs, rt, rd,
//   shamt, imm, target        instruction fields
//   addr_load, addr_in        pointer load (IDLE only)
//   mem_addr, mem_mode,
//   mem_datain, mem_data_out  memory port (mode 0 = write, 1 = read)
//   wr_ptr, word_last         current pointer, last encoded word
//   done, err, mismatch       completion pulse and status
// -----------------------------------------------------------------------------
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 12,
  parameter int VERIFY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_code,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_mode,
  output logic [31:0]       mem_datain,
  input  logic [31:0]       mem_data_out,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [31:0]       word_last,
  output logic              done,
  output logic              err,
  output logic              mismatch
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_mode_q;
  logic [31:0]       mem_datain_q;
  logic [31:0]       word_last_q;
  logic              err_q;
  logic              mismatch_q;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic [ADDR_W-1:0] tgt_ptr;

  instr_field_packer u_packer (
    .op_code (op_code),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .target  (target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // A pointer load in the accept cycle redirects that same word.
  assign tgt_ptr = addr_load ? addr_in : wr_ptr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid) state_d = enc_illegal ? ST_RESP : ST_WRITE;
      ST_WRITE: state_d = (VERIFY != 0) ? ST_RD0 : ST_RESP;
      ST_RD0:   state_d = ST_RD1;
      ST_RD1:   state_d = ST_CMP;
      ST_CMP:   state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    done     = (state_q == ST_RESP);
  end

  // Pointer, memory port and status registers. The memory port is registered
  // so reset drops mem_mode to read at once, blocking any further write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= BASE_PTR;
      mem_addr_q   <= BASE_PTR;
      mem_mode_q   <= 1'b1;
      mem_datain_q <= '0;
      word_last_q  <= '0;
      err_q        <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (addr_load) wr_ptr_q <= addr_in;
          if (in_valid) begin
            if (enc_illegal) begin
              err_q      <= 1'b1;
              mismatch_q <= 1'b0;
            end else begin
              mem_mode_q   <= 1'b0;
              mem_addr_q   <= tgt_ptr;
              mem_datain_q <= enc_word;
              word_last_q  <= enc_word;
            end
          end
        end
        ST_WRITE: begin
          // mem_addr keeps the written address for the readback states.
          mem_mode_q <= 1'b1;
          wr_ptr_q   <= wr_ptr_q + PTR_ONE;
          if (VERIFY == 0) begin
            err_q      <= 1'b0;
            mismatch_q <= 1'b0;
          end
        end
        ST_CMP: begin
          err_q      <= 1'b0;
          mismatch_q <= (mem_data_out != word_last_q);
        end
        default: ;
      endcase
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_mode   = mem_mode_q;
  assign mem_datain = mem_datain_q;
  assign word_last  = word_last_q;
  assign err        = err_q;
  assign mismatch   = mismatch_q;

endmodule
